piece_move_ctrl: RTL and testbench

Sequencer for the falling-piece datapath on the 24-px playfield grid. Merges player key edges with the gravity tick and issues at most one move at a time. Each move is validated through a collision-check handshake with the board store before the piece position is committed. Also drives lock, respawn and game-over; sits between the keycode source and the board/renderer.

---
 rtl/piece_move_ctrl_pkg.sv | 37 +++
 rtl/piece_move_ctrl_if.sv | 27 ++
 rtl/piece_move_ctrl_drop_timer.sv | 30 +++
 rtl/piece_move_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_piece_move_ctrl.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/piece_move_ctrl_pkg.sv
// Shared types and constants for the falling-piece move sequencer.
// The grid defaults here are the top-level parameter defaults.
package piece_ctrl_pkg;

  localparam int COORD_W = 10;

  typedef enum logic [2:0] {
    IDLE,
    QUERY,
    LOCK,
    SPAWN_CHK,
    DEAD
  } state_t;

  typedef enum logic {
    KIND_H,
    KIND_D
  } move_kind_t;

  localparam logic [7:0] KEY_LEFT  = 8'h04;
  localparam logic [7:0] KEY_RIGHT = 8'h07;
  localparam logic [7:0] KEY_DOWN  = 8'h16;

  localparam int DEF_X_CENTER    = 320;
  localparam int DEF_Y_SPAWN     = 24;
  localparam int DEF_X_MIN       = 224;
  localparam int DEF_X_MAX       = 420;
  localparam int DEF_Y_MAX       = 460;
  localparam int DEF_STEP        = 24;
  localparam int DEF_DROP_PERIOD = 50;

  // A key press is the first non-zero code after a zero code.
  function automatic logic is_key_edge(input logic [7:0] code, input logic [7:0] prev);
    return (code != 8'h00) && (prev == 8'h00);
  endfunction

endpackage

// File: rtl/piece_move_ctrl_if.sv
// Board-store handshake: collision query and lock write.
// master = move sequencer, slave = board store.
interface piece_move_ctrl_if;
  import piece_ctrl_pkg::*;

  logic               chk_req;
  logic [COORD_W-1:0] chk_x;
  logic [COORD_W-1:0] chk_y;
  logic               chk_ack;
  logic               chk_blocked;

  logic               lock_req;
  logic [COORD_W-1:0] lock_x;
  logic [COORD_W-1:0] lock_y;
  logic               lock_ack;

  modport master (
    output chk_req, chk_x, chk_y, lock_req, lock_x, lock_y,
    input  chk_ack, chk_blocked, lock_ack
  );

  modport slave (
    input  chk_req, chk_x, chk_y, lock_req, lock_x, lock_y,
    output chk_ack, chk_blocked, lock_ack
  );

endinterface

// File: rtl/piece_move_ctrl_drop_timer.sv
// Gravity timer: counts 0..DROP_PERIOD-1 while enabled and pulses tick
// in the cycle it wraps back to zero.
module drop_timer #(
  parameter int DROP_PERIOD = 50
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DROP_PERIOD > 1) ? $clog2(DROP_PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(DROP_PERIOD - 1);

  logic [CW-1:0] cnt;

  assign tick = en && !clr && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/piece_move_ctrl.sv
// Falling-piece move sequencer: merges key edges and gravity ticks, validates
// each move with the board store, then commits, locks, respawns or ends the game.
module piece_move_ctrl
  import piece_ctrl_pkg::*;
#(
  parameter int X_CENTER    = DEF_X_CENTER,
  parameter int Y_SPAWN     = DEF_Y_SPAWN,
  parameter int X_MIN       = DEF_X_MIN,
  parameter int X_MAX       = DEF_X_MAX,
  parameter int Y_MAX       = DEF_Y_MAX,
  parameter int STEP        = DEF_STEP,
  parameter int DROP_PERIOD = DEF_DROP_PERIOD
) (
  input  logic               frame_clk,
  input  logic               Reset_n,
  input  logic [7:0]         keycode,
  piece_move_ctrl_if.master  bus,
  output logic [COORD_W-1:0] PieceX,
  output logic [COORD_W-1:0] PieceY,
  output logic               alive
);

  localparam int WW = COORD_W + 1;
  localparam logic [COORD_W-1:0] X_CENTER_C = COORD_W'(X_CENTER);
  localparam logic [COORD_W-1:0] Y_SPAWN_C  = COORD_W'(Y_SPAWN);
  localparam logic [COORD_W-1:0] STEP_C     = COORD_W'(STEP);
  localparam logic [WW-1:0]      STEP_W     = WW'(STEP);
  localparam logic [WW-1:0]      LEFT_MIN_W = WW'(X_MIN + STEP);
  localparam logic [WW-1:0]      X_MAX_W    = WW'(X_MAX);
  localparam logic [WW-1:0]      FLOOR_W    = WW'(Y_MAX - STEP);

  state_t     state;
  move_kind_t kind;
  logic [7:0] prev_keycode;
  logic       pend_h;
  logic       pend_right;
  logic       pend_g;

  logic               key_edge;
  logic               edge_h;
  logic               edge_g;
  logic               left_ok;
  logic               right_ok;
  logic               at_floor;
  logic [COORD_W-1:0] x_left;
  logic [COORD_W-1:0] x_right;
  logic [COORD_W-1:0] y_down;
  logic               lock_done;
  logic               accept_events;
  logic               drop_tick;

  assign key_edge = is_key_edge(keycode, prev_keycode);
  assign edge_h   = key_edge && ((keycode == KEY_LEFT) || (keycode == KEY_RIGHT));
  assign edge_g   = key_edge && (keycode == KEY_DOWN);

  // Bounds are evaluated one bit wider so the left test cannot underflow.
  assign left_ok  = {1'b0, PieceX} >= LEFT_MIN_W;
  assign right_ok = ({1'b0, PieceX} + STEP_W) <= X_MAX_W;
  assign at_floor = ({1'b0, PieceY} + STEP_W) > FLOOR_W;
  assign x_left   = PieceX - STEP_C;
  assign x_right  = PieceX + STEP_C;
  assign y_down   = PieceY + STEP_C;

  assign lock_done     = (state == LOCK) && bus.lock_ack;
  assign accept_events = (state != DEAD) && !lock_done;

  drop_timer #(
    .DROP_PERIOD (DROP_PERIOD)
  ) u_drop_timer (
    .clk   (frame_clk),
    .rst_n (Reset_n),
    .en    (state != DEAD),
    .clr   (lock_done),
    .tick  (drop_tick)
  );

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state        <= IDLE;
      kind         <= KIND_H;
      prev_keycode <= '0;
      pend_h       <= 1'b0;
      pend_right   <= 1'b0;
      pend_g       <= 1'b0;
      PieceX       <= X_CENTER_C;
      PieceY       <= Y_SPAWN_C;
      alive        <= 1'b1;
      bus.chk_req  <= 1'b0;
      bus.chk_x    <= '0;
      bus.chk_y    <= '0;
      bus.lock_req <= 1'b0;
      bus.lock_x   <= '0;
      bus.lock_y   <= '0;
    end else begin
      prev_keycode <= keycode;

      unique case (state)
        IDLE: begin
          if (pend_h) begin
            pend_h <= 1'b0;
            if (pend_right ? right_ok : left_ok) begin
              bus.chk_req <= 1'b1;
              bus.chk_x   <= pend_right ? x_right : x_left;
              bus.chk_y   <= PieceY;
              kind        <= KIND_H;
              state       <= QUERY;
            end
          end else if (pend_g) begin
            pend_g <= 1'b0;
            if (at_floor) begin
              bus.lock_req <= 1'b1;
              bus.lock_x   <= PieceX;
              bus.lock_y   <= PieceY;
              state        <= LOCK;
            end else begin
              bus.chk_req <= 1'b1;
              bus.chk_x   <= PieceX;
              bus.chk_y   <= y_down;
              kind        <= KIND_D;
              state       <= QUERY;
            end
          end
        end

        QUERY: begin
          if (bus.chk_ack) begin
            bus.chk_req <= 1'b0;
            if (!bus.chk_blocked) begin
              PieceX <= bus.chk_x;
              PieceY <= bus.chk_y;
              state  <= IDLE;
            end else if (kind == KIND_D) begin
              bus.lock_req <= 1'b1;
              bus.lock_x   <= PieceX;
              bus.lock_y   <= PieceY;
              state        <= LOCK;
            end else begin
              state <= IDLE;
            end
          end
        end

        LOCK: begin
          if (bus.lock_ack) begin
            bus.lock_req <= 1'b0;
            PieceX       <= X_CENTER_C;
            PieceY       <= Y_SPAWN_C;
            pend_h       <= 1'b0;
            pend_g       <= 1'b0;
            bus.chk_req  <= 1'b1;
            bus.chk_x    <= X_CENTER_C;
            bus.chk_y    <= Y_SPAWN_C;
            state        <= SPAWN_CHK;
          end
        end

        SPAWN_CHK: begin
          if (bus.chk_ack) begin
            bus.chk_req <= 1'b0;
            if (bus.chk_blocked) begin
              alive <= 1'b0;
              state <= DEAD;
            end else begin
              state <= IDLE;
            end
          end
        end

        DEAD: begin
          bus.chk_req  <= 1'b0;
          bus.lock_req <= 1'b0;
        end

        default: state <= IDLE;
      endcase

      // Placed after the case so an event arriving while its flag is being
      // serviced stays pending; a lock completion discards everything.
      if (accept_events) begin
        if (edge_h) begin
          pend_h     <= 1'b1;
          pend_right <= (keycode == KEY_RIGHT);
        end
        if (edge_g || drop_tick) begin
          pend_g <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_piece_move_ctrl.sv
// Directed bench for piece_move_ctrl: a table of key vectors plus hand-written
// gravity, lock/respawn, game-over, simultaneous-event and reset sequences.
module tb_piece_move_ctrl;
  import piece_ctrl_pkg::*;

  logic       frame_clk;
  logic       Reset_n;
  logic [7:0] keycode;
  logic [9:0] PieceX;
  logic [9:0] PieceY;
  logic       alive;

  piece_move_ctrl_if bus ();

  piece_move_ctrl dut (
    .frame_clk (frame_clk),
    .Reset_n   (Reset_n),
    .keycode   (keycode),
    .bus       (bus),
    .PieceX    (PieceX),
    .PieceY    (PieceY),
    .alive     (alive)
  );

  initial begin
    frame_clk = 1'b0;
    forever #5 frame_clk = ~frame_clk;
  end

  // Board model: answers each request on the next falling edge when enabled.
  logic auto_chk;
  logic auto_lock;
  logic blk_cfg;
  int   q_cnt;
  int   lock_cnt;
  int   q_x [64];
  int   q_y [64];

  initial begin
    bus.chk_ack     = 1'b0;
    bus.chk_blocked = 1'b0;
    bus.lock_ack    = 1'b0;
    q_cnt           = 0;
    lock_cnt        = 0;
    forever begin
      @(negedge frame_clk);
      if (auto_chk && bus.chk_req && !bus.chk_ack) begin
        bus.chk_ack     = 1'b1;
        bus.chk_blocked = blk_cfg;
        if (q_cnt < 64) begin
          q_x[q_cnt] = int'(bus.chk_x);
          q_y[q_cnt] = int'(bus.chk_y);
        end
        q_cnt++;
        $display("[TB] chk #%0d at (%0d,%0d) blocked=%0b", q_cnt, bus.chk_x, bus.chk_y, blk_cfg);
      end else begin
        bus.chk_ack     = 1'b0;
        bus.chk_blocked = 1'b0;
      end
      if (auto_lock && bus.lock_req && !bus.lock_ack) begin
        bus.lock_ack = 1'b1;
        lock_cnt++;
        $display("[TB] lock #%0d at (%0d,%0d)", lock_cnt, bus.lock_x, bus.lock_y);
      end else begin
        bus.lock_ack = 1'b0;
      end
    end
  end

  int n_tests;
  int n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge frame_clk);
    keycode = 8'h00;
    Reset_n = 1'b0;
    @(negedge frame_clk);
    @(negedge frame_clk);
    Reset_n = 1'b1;
  endtask

  // Key held one cycle, then 3 more cycles for launch, ack and commit.
  task automatic press(input logic [7:0] key);
    keycode = key;
    @(negedge frame_clk);
    keycode = 8'h00;
    repeat (3) @(negedge frame_clk);
  endtask

  typedef struct {
    logic [7:0] key;
    int         exp_q;
    int         cx;
    int         cy;
    int         px;
    int         py;
  } vec_t;

  vec_t vecs [9];
  int   qb;
  int   waited;

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    auto_chk  = 1'b1;
    auto_lock = 1'b1;
    blk_cfg   = 1'b0;
    keycode   = 8'h00;
    Reset_n   = 1'b0;

    vecs[0] = '{KEY_LEFT,  1, 296, 24, 296, 24};
    vecs[1] = '{KEY_RIGHT, 1, 320, 24, 320, 24};
    vecs[2] = '{KEY_RIGHT, 1, 344, 24, 344, 24};
    vecs[3] = '{KEY_RIGHT, 1, 368, 24, 368, 24};
    vecs[4] = '{KEY_RIGHT, 1, 392, 24, 392, 24};
    vecs[5] = '{KEY_RIGHT, 1, 416, 24, 416, 24};
    vecs[6] = '{KEY_RIGHT, 0, 0,   0,  416, 24};
    vecs[7] = '{8'h05,     0, 0,   0,  416, 24};
    vecs[8] = '{KEY_DOWN,  1, 416, 48, 416, 48};

    // Reset state
    repeat (2) @(negedge frame_clk);
    check("rst_px", PieceX, 320);
    check("rst_py", PieceY, 24);
    check("rst_alive", alive, 1);
    check("rst_chk_req", bus.chk_req, 0);
    check("rst_lock_req", bus.lock_req, 0);
    check("rst_chk_x", bus.chk_x, 0);
    check("rst_lock_y", bus.lock_y, 0);
    $display("[TB] reset: PieceX=%0d PieceY=%0d alive=%0b", PieceX, PieceY, alive);
    @(negedge frame_clk);
    Reset_n = 1'b1;
    @(negedge frame_clk);

    // Table of single key presses, finished well before the first gravity tick
    for (int i = 0; i < 9; i++) begin
      qb = q_cnt;
      press(vecs[i].key);
      check($sformatf("v%0d_qcount", i), q_cnt - qb, vecs[i].exp_q);
      if (vecs[i].exp_q > 0) begin
        check($sformatf("v%0d_chk_x", i), q_x[q_cnt-1], vecs[i].cx);
        check($sformatf("v%0d_chk_y", i), q_y[q_cnt-1], vecs[i].cy);
      end
      check($sformatf("v%0d_px", i), PieceX, vecs[i].px);
      check($sformatf("v%0d_py", i), PieceY, vecs[i].py);
      $display("[TB] vec %0d key=%02h -> PieceX=%0d PieceY=%0d queries=%0d",
               i, vecs[i].key, PieceX, PieceY, q_cnt - qb);
    end

    // Left wall: four moves to 224, fifth is refused without a query
    do_reset();
    @(negedge frame_clk);
    qb = q_cnt;
    for (int i = 0; i < 5; i++) press(KEY_LEFT);
    check("lwall_qcount", q_cnt - qb, 4);
    check("lwall_px", PieceX, 224);
    $display("[TB] left wall: PieceX=%0d queries=%0d", PieceX, q_cnt - qb);

    // Gravity to the floor, lock, respawn
    do_reset();
    qb     = q_cnt;
    waited = 0;
    while (!bus.lock_req && waited < 2000) begin
      @(negedge frame_clk);
      waited++;
    end
    check("grav_lock_seen", bus.lock_req, 1);
    check("grav_qcount", q_cnt - qb, 17);
    check("grav_py_floor", PieceY, 432);
    check("grav_lock_x", bus.lock_x, 320);
    check("grav_lock_y", bus.lock_y, 432);
    $display("[TB] gravity: lock_req after %0d cycles at (%0d,%0d)", waited, bus.lock_x, bus.lock_y);
    repeat (6) @(negedge frame_clk);
    check("respawn_px", PieceX, 320);
    check("respawn_py", PieceY, 24);
    check("respawn_qcount", q_cnt - qb, 18);
    check("respawn_chk_x", q_x[q_cnt-1], 320);
    check("respawn_chk_y", q_y[q_cnt-1], 24);
    check("respawn_idle_req", bus.chk_req, 0);
    check("respawn_alive", alive, 1);
    $display("[TB] respawn: PieceX=%0d PieceY=%0d alive=%0b", PieceX, PieceY, alive);

    // Blocked gravity check locks at spawn; blocked spawn check ends the game
    blk_cfg = 1'b1;
    do_reset();
    qb     = q_cnt;
    waited = 0;
    while (!bus.lock_req && waited < 200) begin
      @(negedge frame_clk);
      waited++;
    end
    check("blk_lock_seen", bus.lock_req, 1);
    check("blk_qcount", q_cnt - qb, 1);
    check("blk_chk_y", q_y[q_cnt-1], 48);
    check("blk_lock_x", bus.lock_x, 320);
    check("blk_lock_y", bus.lock_y, 24);
    waited = 0;
    while (alive && waited < 20) begin
      @(negedge frame_clk);
      waited++;
    end
    check("dead_alive", alive, 0);
    qb = q_cnt;
    press(KEY_LEFT);
    repeat (80) @(negedge frame_clk);
    check("dead_qcount", q_cnt - qb, 0);
    check("dead_chk_req", bus.chk_req, 0);
    check("dead_lock_req", bus.lock_req, 0);
    check("dead_px", PieceX, 320);
    $display("[TB] game over: alive=%0b queries after=%0d", alive, q_cnt - qb);
    blk_cfg = 1'b0;

    // Left edge and gravity tick sampled on the same clock edge
    do_reset();
    repeat (49) @(negedge frame_clk);
    qb      = q_cnt;
    keycode = KEY_LEFT;
    @(negedge frame_clk);
    keycode = 8'h00;
    repeat (10) @(negedge frame_clk);
    check("same_qcount", q_cnt - qb, 2);
    check("same_q0_x", q_x[qb], 296);
    check("same_q0_y", q_y[qb], 24);
    check("same_q1_x", q_x[qb+1], 296);
    check("same_q1_y", q_y[qb+1], 48);
    check("same_px", PieceX, 296);
    check("same_py", PieceY, 48);
    $display("[TB] simultaneous: PieceX=%0d PieceY=%0d", PieceX, PieceY);

    // Reset while a query is outstanding and never acknowledged
    do_reset();
    @(negedge frame_clk);
    press(KEY_LEFT);
    check("midrst_pre_px", PieceX, 296);
    auto_chk = 1'b0;
    keycode  = KEY_RIGHT;
    @(negedge frame_clk);
    keycode = 8'h00;
    waited  = 0;
    while (!bus.chk_req && waited < 10) begin
      @(negedge frame_clk);
      waited++;
    end
    check("midrst_req_up", bus.chk_req, 1);
    check("midrst_chk_x", bus.chk_x, 320);
    Reset_n = 1'b0;
    #1;
    check("midrst_req_drop", bus.chk_req, 0);
    check("midrst_px", PieceX, 320);
    check("midrst_py", PieceY, 24);
    check("midrst_alive", alive, 1);
    $display("[TB] mid-handshake reset: chk_req=%0b PieceX=%0d", bus.chk_req, PieceX);
    @(negedge frame_clk);
    auto_chk = 1'b1;
    Reset_n  = 1'b1;
    repeat (2) @(negedge frame_clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
